// File: rtl/memmap_pkg.sv
// memmap_pkg: shared types and defaults for the memmap_bus slice.
// Holds the FSM state enum, decode region enum and default MMIO base.
package memmap_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BRAM_ACC  = 3'd1,
        BRAM_DATA = 3'd2,
        MMIO_ACC  = 3'd3,
        ERR       = 3'd4,
        DONE      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        REG_BRAM    = 2'd0,
        REG_MMIO    = 2'd1,
        REG_INVALID = 2'd2
    } region_t;

    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_FFC0;

endpackage

// File: rtl/memmap_decode.sv
// memmap_decode: combinational address decoder for memmap_bus.
// Maps a CPU address to BRAM, one MMIO slot, or invalid.
module memmap_decode
    import memmap_pkg::*;
#(
    parameter int          BRAM_WIDTH = 12,
    parameter int          NUM_SLOTS  = 4,
    parameter int          SLOT_AW    = 4,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF,
    parameter int          SW         = 2
) (
    input  logic [31:0]   cpu_addr,
    output region_t       region,
    output logic [SW-1:0] slot
);

    localparam logic [32:0] SPAN     = 33'(NUM_SLOTS) << SLOT_AW;
    localparam logic [32:0] MMIO_TOP = {1'b0, MMIO_BASE} + SPAN;
    localparam logic [32:0] BRAM_TOP = 33'd1 << BRAM_WIDTH;

    // Slot window must not wrap past the top of the 32-bit space.
    generate
        if (MMIO_TOP > 33'h1_0000_0000) begin : g_wrap
            $error("memmap_decode: MMIO slot range wraps past 2^32");
        end
        if (NUM_SLOTS < 1 || NUM_SLOTS > 16) begin : g_slots
            $error("memmap_decode: NUM_SLOTS must be 1..16");
        end
    endgenerate

    logic [31:0] off;

    assign off = cpu_addr - MMIO_BASE;

    // BRAM takes priority; otherwise test the contiguous slot window.
    always_comb begin
        region = REG_INVALID;
        slot   = '0;
        if ({1'b0, cpu_addr} < BRAM_TOP) begin
            region = REG_BRAM;
        end else if (cpu_addr >= MMIO_BASE && {1'b0, off} < SPAN) begin
            region = REG_MMIO;
            slot   = SW'(off >> SLOT_AW);
        end
    end

endmodule

// File: rtl/memmap_bus.sv
// memmap_bus: sequential CPU memory map with BRAM, MMIO slots and errors.
// Define MEMMAP_BUS_TIMEOUT_EN to abort MMIO accesses after TIMEOUT waits.
module memmap_bus
    import memmap_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          BRAM_WIDTH = 12,
    parameter int          NUM_SLOTS  = 4,
    parameter int          SLOT_AW    = 4,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF,
    parameter int          TIMEOUT    = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_req,
    input  logic [31:0]                     cpu_addr,
    input  logic                            cpu_write,
    input  logic [DATA_WIDTH-1:0]           cpu_data_out,
    output logic [DATA_WIDTH-1:0]           cpu_data_in,
    output logic                            cpu_ready,
    output logic                            cpu_err,
    output logic [BRAM_WIDTH-1:0]           bram_addr,
    output logic                            bram_write,
    output logic [DATA_WIDTH-1:0]           bram_data_in,
    input  logic [DATA_WIDTH-1:0]           bram_data_out,
    output logic [NUM_SLOTS-1:0]            mmio_req,
    output logic [SLOT_AW-1:0]              mmio_addr,
    output logic                            mmio_write,
    output logic [DATA_WIDTH-1:0]           mmio_data_out,
    input  logic [NUM_SLOTS*DATA_WIDTH-1:0] mmio_data_in,
    input  logic [NUM_SLOTS-1:0]            mmio_ack,
    output logic [7:0]                      err_count,
    output logic [31:0]                     err_addr
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    // A zero timeout would abort before the first ack could be seen.
    generate
        if (TIMEOUT < 1) begin : g_tmo
            $error("memmap_bus: TIMEOUT must be at least 1");
        end
    endgenerate

    state_t                state_q, state_d;
    region_t               region_dec;
    logic [SW-1:0]         slot_dec;
    logic [31:0]           addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         slot_q;
    logic                  err_flag_q;
    logic [7:0]            err_count_q;
    logic [31:0]           err_addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  ack_sel;
    logic [DATA_WIDTH-1:0] slice_sel;

`ifdef MEMMAP_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_q;
`endif

    memmap_decode #(
        .BRAM_WIDTH (BRAM_WIDTH),
        .NUM_SLOTS  (NUM_SLOTS),
        .SLOT_AW    (SLOT_AW),
        .MMIO_BASE  (MMIO_BASE),
        .SW         (SW)
    ) u_decode (
        .cpu_addr (cpu_addr),
        .region   (region_dec),
        .slot     (slot_dec)
    );

    // Pick the selected slot's ack and read data; other slots are ignored.
    always_comb begin
        ack_sel   = 1'b0;
        slice_sel = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q == SW'(i)) begin
                ack_sel   = mmio_ack[i];
                slice_sel = mmio_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic and the read value captured on entry to DONE.
    always_comb begin
        state_d = state_q;
        rdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    unique case (region_dec)
                        REG_BRAM: state_d = BRAM_ACC;
                        REG_MMIO: state_d = MMIO_ACC;
                        default:  state_d = ERR;
                    endcase
                end
            end
            BRAM_ACC: begin
                state_d = write_q ? DONE : BRAM_DATA;
            end
            BRAM_DATA: begin
                state_d = DONE;
                rdata_d = bram_data_out;
            end
            MMIO_ACC: begin
                if (ack_sel) begin
                    state_d = DONE;
                    rdata_d = write_q ? '0 : slice_sel;
                end
`ifdef MEMMAP_BUS_TIMEOUT_EN
                else if (wait_q == CW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end
`endif
            end
            ERR: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding registers for the accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            slot_q  <= '0;
        end else if (state_q == IDLE && cpu_req) begin
            addr_q  <= cpu_addr;
            write_q <= cpu_write;
            wdata_q <= cpu_data_out;
            slot_q  <= slot_dec;
        end
    end

    // Error flag, saturating error count and last error address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else if (state_q == IDLE && cpu_req) begin
            err_flag_q <= 1'b0;
        end else if (state_q == ERR) begin
            err_flag_q <= 1'b1;
            err_addr_q <= addr_q;
            if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // Response data only changes when entering DONE, so it stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state_d == DONE && state_q != DONE) begin
            rdata_q <= rdata_d;
        end
    end

`ifdef MEMMAP_BUS_TIMEOUT_EN
    // Wait counter: cleared on entry to MMIO_ACC, counts cycles without ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (state_q != MMIO_ACC) begin
            wait_q <= '0;
        end else if (!ack_sel) begin
            wait_q <= wait_q + CW'(1);
        end
    end
`endif

    // Bus-side outputs are driven only in their access states.
    always_comb begin
        bram_addr     = '0;
        bram_write    = 1'b0;
        bram_data_in  = '0;
        mmio_req      = '0;
        mmio_addr     = '0;
        mmio_write    = 1'b0;
        mmio_data_out = '0;
        if (state_q == BRAM_ACC) begin
            bram_addr    = addr_q[BRAM_WIDTH-1:0];
            bram_write   = write_q;
            bram_data_in = wdata_q;
        end
        if (state_q == MMIO_ACC) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mmio_req[i] = (slot_q == SW'(i));
            end
            mmio_addr     = addr_q[SLOT_AW-1:0];
            mmio_write    = write_q;
            mmio_data_out = wdata_q;
        end
    end

    assign cpu_ready   = (state_q == DONE);
    assign cpu_err     = (state_q == DONE) && err_flag_q;
    assign cpu_data_in = rdata_q;
    assign err_count   = err_count_q;
    assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_memmap_bus.sv
// tb_memmap_bus: directed self-checking bench for memmap_bus.
// Covers BRAM, MMIO waits, invalid accesses, reset and the timeout build.
module tb_memmap_bus;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_data_out;
    logic [7:0]  cpu_data_in;
    logic        cpu_ready;
    logic        cpu_err;
    logic [11:0] bram_addr;
    logic        bram_write;
    logic [7:0]  bram_data_in;
    logic [7:0]  bram_data_out;
    logic [3:0]  mmio_req;
    logic [3:0]  mmio_addr;
    logic        mmio_write;
    logic [7:0]  mmio_data_out;
    logic [31:0] mmio_data_in;
    logic [3:0]  mmio_ack;
    logic [7:0]  err_count;
    logic [31:0] err_addr;

    int tests;
    int fails;

    logic [7:0] mem [0:4095];

    memmap_bus dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_write     (cpu_write),
        .cpu_data_out  (cpu_data_out),
        .cpu_data_in   (cpu_data_in),
        .cpu_ready     (cpu_ready),
        .cpu_err       (cpu_err),
        .bram_addr     (bram_addr),
        .bram_write    (bram_write),
        .bram_data_in  (bram_data_in),
        .bram_data_out (bram_data_out),
        .mmio_req      (mmio_req),
        .mmio_addr     (mmio_addr),
        .mmio_write    (mmio_write),
        .mmio_data_out (mmio_data_out),
        .mmio_data_in  (mmio_data_in),
        .mmio_ack      (mmio_ack),
        .err_count     (err_count),
        .err_addr      (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (bram_write) mem[bram_addr] <= bram_data_in;
        bram_data_out <= mem[bram_addr];
    end

    // Present a request for one IDLE cycle; returns #1 after the accept edge.
    task automatic issue(input logic [31:0] a, input logic w,
                         input logic [7:0] d);
        @(posedge clk); #1;
        cpu_req      = 1'b1;
        cpu_addr     = a;
        cpu_write    = w;
        cpu_data_out = d;
        @(posedge clk); #1;
        cpu_req      = 1'b0;
        cpu_addr     = '0;
        cpu_write    = 1'b0;
        cpu_data_out = '0;
    endtask

    // Count edges after accept until cpu_ready; -1 if it never came.
    task automatic wait_ready(output int lat);
        lat = -1;
        for (int n = 2; n <= 60; n++) begin
            @(posedge clk); #1;
            if (cpu_ready) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        tests++;
        if (cpu_ready !== 1'b0 || cpu_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: ready=%b err=%b want 0 0",
                     cpu_ready, cpu_err);
        end
        tests++;
        if (cpu_data_in !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: got %h want 00", cpu_data_in);
        end
        tests++;
        if (err_count !== 8'h00 || err_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_err: cnt=%h addr=%h want 0 0",
                     err_count, err_addr);
        end
        tests++;
        if (bram_write !== 1'b0 || bram_addr !== 12'h0 || mmio_req !== 4'h0
            || mmio_write !== 1'b0 || mmio_addr !== 4'h0) begin
            fails++;
            $display("FAIL reset_bus: bw=%b ba=%h mr=%b mw=%b ma=%h want 0",
                     bram_write, bram_addr, mmio_req, mmio_write, mmio_addr);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_bram;
        int lat;
        issue(32'h100, 1'b1, 8'd44);
        tests++;
        if (bram_write !== 1'b1 || bram_addr !== 12'h100
            || bram_data_in !== 8'd44) begin
            fails++;
            $display("FAIL bram_wr_bus: bw=%b ba=%h bd=%0d want 1 100 44",
                     bram_write, bram_addr, bram_data_in);
        end
        wait_ready(lat);
        tests++;
        if (lat !== 2 || cpu_err !== 1'b0) begin
            fails++;
            $display("FAIL bram_wr_lat: lat=%0d err=%b want 2 0", lat, cpu_err);
        end
        tests++;
        if (cpu_data_in !== 8'h00 || bram_write !== 1'b0) begin
            fails++;
            $display("FAIL bram_wr_done: data=%0d bw=%b want 0 0",
                     cpu_data_in, bram_write);
        end
        issue(32'h100, 1'b0, 8'd0);
        tests++;
        if (bram_write !== 1'b0 || bram_addr !== 12'h100) begin
            fails++;
            $display("FAIL bram_rd_bus: bw=%b ba=%h want 0 100",
                     bram_write, bram_addr);
        end
        wait_ready(lat);
        tests++;
        if (lat !== 3 || cpu_err !== 1'b0) begin
            fails++;
            $display("FAIL bram_rd_lat: lat=%0d err=%b want 3 0", lat, cpu_err);
        end
        tests++;
        if (cpu_data_in !== 8'd44) begin
            fails++;
            $display("FAIL bram_rd_data: got %0d want 44", cpu_data_in);
        end
    endtask

    task automatic test_mmio_zero_wait;
        int lat;
        mmio_data_in = 32'h0F_33_22_11;
        mmio_ack     = 4'b1000;
        issue(32'hFFFF_FFF5, 1'b0, 8'd0);
        tests++;
        if (mmio_req !== 4'b1000 || mmio_addr !== 4'd5
            || mmio_write !== 1'b0) begin
            fails++;
            $display("FAIL mmio0_bus: req=%b addr=%h wr=%b want 1000 5 0",
                     mmio_req, mmio_addr, mmio_write);
        end
        wait_ready(lat);
        mmio_ack = 4'b0000;
        tests++;
        if (lat !== 2 || cpu_err !== 1'b0) begin
            fails++;
            $display("FAIL mmio0_lat: lat=%0d err=%b want 2 0", lat, cpu_err);
        end
        tests++;
        if (cpu_data_in !== 8'd15 || mmio_req !== 4'b0000) begin
            fails++;
            $display("FAIL mmio0_data: data=%0d req=%b want 15 0000",
                     cpu_data_in, mmio_req);
        end
    endtask

    task automatic test_mmio_wait;
        int lat;
        int reqc;
        int bad_req;
        lat     = -1;
        reqc    = 0;
        bad_req = 0;
        mmio_data_in = 32'h0F_33_22_11;
        issue(32'hFFFF_FFC3, 1'b1, 8'h5A);
        tests++;
        if (mmio_addr !== 4'd3 || mmio_write !== 1'b1
            || mmio_data_out !== 8'h5A) begin
            fails++;
            $display("FAIL mmiow_bus: addr=%h wr=%b d=%h want 3 1 5a",
                     mmio_addr, mmio_write, mmio_data_out);
        end
        for (int n = 1; n <= 40; n++) begin
            if (mmio_req[0]) reqc++;
            if (mmio_req[3:1] !== 3'b000) bad_req++;
            mmio_ack = (n == 2) ? 4'b0010 : (n == 5) ? 4'b0001 : 4'b0000;
            @(posedge clk); #1;
            if (cpu_ready) begin
                lat = n + 1;
                break;
            end
        end
        mmio_ack = 4'b0000;
        tests++;
        if (lat !== 6) begin
            fails++;
            $display("FAIL mmiow_lat: lat=%0d want 6", lat);
        end
        tests++;
        if (reqc !== 5 || bad_req !== 0) begin
            fails++;
            $display("FAIL mmiow_req: cycles=%0d other=%0d want 5 0",
                     reqc, bad_req);
        end
        tests++;
        if (cpu_err !== 1'b0 || cpu_data_in !== 8'h00) begin
            fails++;
            $display("FAIL mmiow_done: err=%b data=%h want 0 00",
                     cpu_err, cpu_data_in);
        end
    endtask

    task automatic test_invalid;
        int lat;
        issue(32'h7FFF_FFFF, 1'b1, 8'd68);
        tests++;
        if (bram_write !== 1'b0 || mmio_req !== 4'b0000) begin
            fails++;
            $display("FAIL inv_bus: bw=%b req=%b want 0 0000",
                     bram_write, mmio_req);
        end
        wait_ready(lat);
        tests++;
        if (lat !== 2 || cpu_err !== 1'b1) begin
            fails++;
            $display("FAIL inv_lat: lat=%0d err=%b want 2 1", lat, cpu_err);
        end
        tests++;
        if (err_count !== 8'd1 || err_addr !== 32'h7FFF_FFFF
            || cpu_data_in !== 8'h00) begin
            fails++;
            $display("FAIL inv_rec: cnt=%0d addr=%h data=%h want 1 7fffffff 0",
                     err_count, err_addr, cpu_data_in);
        end
        for (int k = 0; k < 300; k++) begin
            issue(32'h0001_0000 + k, 1'b0, 8'd0);
            wait_ready(lat);
        end
        tests++;
        if (err_count !== 8'd255 || err_addr !== 32'h0001_012B) begin
            fails++;
            $display("FAIL inv_sat: cnt=%0d addr=%h want 255 0001012b",
                     err_count, err_addr);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        issue(32'hFFFF_FFD2, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (mmio_req !== 4'b0010 || mmio_addr !== 4'd2) begin
            fails++;
            $display("FAIL rmid_pre: req=%b addr=%h want 0010 2",
                     mmio_req, mmio_addr);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (mmio_req !== 4'b0000 || mmio_addr !== 4'h0 || cpu_ready !== 1'b0
            || bram_write !== 1'b0) begin
            fails++;
            $display("FAIL rmid_bus: req=%b addr=%h rdy=%b bw=%b want 0",
                     mmio_req, mmio_addr, cpu_ready, bram_write);
        end
        tests++;
        if (err_count !== 8'h00 || err_addr !== 32'h0
            || cpu_data_in !== 8'h00) begin
            fails++;
            $display("FAIL rmid_regs: cnt=%h addr=%h data=%h want 0",
                     err_count, err_addr, cpu_data_in);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        issue(32'h100, 1'b0, 8'd0);
        wait_ready(lat);
        tests++;
        if (lat !== 3 || cpu_data_in !== 8'd44 || cpu_err !== 1'b0) begin
            fails++;
            $display("FAIL rmid_after: lat=%0d data=%0d err=%b want 3 44 0",
                     lat, cpu_data_in, cpu_err);
        end
    endtask

    task automatic test_timeout;
        int lat;
        mmio_data_in = 32'h0F_77_22_11;
        mmio_ack     = 4'b0000;
        issue(32'hFFFF_FFE0, 1'b0, 8'd0);
`ifdef MEMMAP_BUS_TIMEOUT_EN
        wait_ready(lat);
        tests++;
        if (lat !== 17 || cpu_err !== 1'b1 || cpu_data_in !== 8'h00) begin
            fails++;
            $display("FAIL tmo: lat=%0d err=%b data=%h want 17 1 00",
                     lat, cpu_err, cpu_data_in);
        end
        tests++;
        if (err_addr !== 32'hFFFF_FFE0) begin
            fails++;
            $display("FAIL tmo_addr: got %h want ffffffe0", err_addr);
        end
`else
        wait_ready(lat);
        tests++;
        if (lat !== -1 || mmio_req !== 4'b0100) begin
            fails++;
            $display("FAIL notmo: lat=%0d req=%b want -1 0100", lat, mmio_req);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`endif
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        cpu_req      = 1'b0;
        cpu_addr     = '0;
        cpu_write    = 1'b0;
        cpu_data_out = '0;
        mmio_data_in = '0;
        mmio_ack     = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        test_reset;
        test_bram;
        test_mmio_zero_wait;
        test_mmio_wait;
        test_invalid;
        test_reset_mid;
        test_timeout;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
